ys_poly_small_ctrl3: RTL and testbench

- Sequencer for poly_small mode 3: g[i] = 3*(g[i-1]-g[i]) for i>0, g[0] = -(3*g[0]).
- Sits directly upstream of the mode-3 execution datapath.
- Drives read addresses/enables of source RAM (ram1, dual port, 4 x 13-bit coeffs per word) and the f_ctr lane-0 select of the datapath.
- Drives write addresses/enables of destination RAM (ram2), aligned to datapath output.
- Datapath carries the lane-3 result of beat k-1 into beat k, so beats are issued back-to-back with no gaps.

---
 rtl/ys_poly_small_ctrl3.sv | 152 +++++++++++++++
 tb/tb_ys_poly_small_ctrl3.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ys_poly_small_ctrl3.sv
// Read/write sequencer for the poly_small mode-3 datapath (g[i] = 3*(g[i-1]-g[i]), g[0] = -3*g[0]).
// Optional cycle counter output cyc_cnt enabled by defining YS_POLY_SMALL_CTRL3_CNT_EN.
`timescale 1ns/1ps
module ys_poly_small_ctrl3 #(
  parameter int N_COEF = 509,
  parameter int AW     = 7,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          ram1_ena,
  output logic          ram1_enb,
  output logic [AW-1:0] ram1_addra,
  output logic [AW-1:0] ram1_addrb,
  output logic          f_ctr,
  output logic          ram2_wea,
  output logic          ram2_web,
`ifdef YS_POLY_SMALL_CTRL3_CNT_EN
  output logic [15:0]   cyc_cnt,
`endif
  output logic [AW-1:0] ram2_addra,
  output logic [AW-1:0] ram2_addrb
);

  localparam int BEATS = (N_COEF + 7) / 8;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e        state_q;
  logic [BW-1:0] beat_q;
  logic [1:0]    drain_q;
  logic          rdEn_q;
  logic [AW-1:0] rdAddrA_q;
  logic [AW-1:0] rdAddrB_q;
  logic          busy_q;
  logic          done_q;

  logic [RD_LAT-1:0] pipeV_q;
  logic [BW-1:0]     pipeBeat_q [RD_LAT];

  logic          wrV;
  logic [BW-1:0] wrBeat;

  // Control FSM; beats issue back-to-back because the datapath carries lane 3 into the next beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      drain_q   <= '0;
      rdEn_q    <= 1'b0;
      rdAddrA_q <= '0;
      rdAddrB_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            beat_q    <= '0;
            rdEn_q    <= 1'b1;
            rdAddrA_q <= '0;
            rdAddrB_q <= AW'(1);
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (beat_q == BW'(BEATS - 1)) begin
            state_q   <= DRAIN;
            drain_q   <= '0;
            rdEn_q    <= 1'b0;
            rdAddrA_q <= '0;
            rdAddrB_q <= '0;
          end else begin
            beat_q    <= beat_q + BW'(1);
            rdAddrA_q <= rdAddrA_q + AW'(2);
            rdAddrB_q <= rdAddrB_q + AW'(2);
          end
        end
        DRAIN: begin
          if (drain_q == 2'(RD_LAT - 1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Delay line matching ram1 read latency so writes line up with datapath output
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipeV_q[i]    <= 1'b0;
        pipeBeat_q[i] <= '0;
      end
    end else begin
      pipeV_q[0]    <= rdEn_q;
      pipeBeat_q[0] <= beat_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipeV_q[i]    <= pipeV_q[i-1];
        pipeBeat_q[i] <= pipeBeat_q[i-1];
      end
    end
  end

  assign wrV    = pipeV_q[RD_LAT-1];
  assign wrBeat = pipeBeat_q[RD_LAT-1];

  assign busy       = busy_q;
  assign done       = done_q;
  assign ram1_ena   = rdEn_q;
  assign ram1_enb   = rdEn_q;
  assign ram1_addra = rdAddrA_q;
  assign ram1_addrb = rdAddrB_q;
  assign ram2_wea   = wrV;
  assign ram2_web   = wrV;
  assign ram2_addra = wrV ? AW'({wrBeat, 1'b0}) : '0;
  assign ram2_addrb = wrV ? AW'({wrBeat, 1'b1}) : '0;
  // Lane 0 of beat 0 has no predecessor, so it uses the -(3*g[0]) form
  assign f_ctr      = !(wrV && (wrBeat == '0));

`ifdef YS_POLY_SMALL_CTRL3_CNT_EN
  logic [15:0] cnt_q;

  // Run-length counter: cleared on accepted start, saturating, held after completion
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      cnt_q <= '0;
    end else if (busy_q && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cyc_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ys_poly_small_ctrl3.sv
// Self-checking bench for ys_poly_small_ctrl3: two configurations (N=509/RD_LAT=1 and N=16/RD_LAT=2)
// checked every cycle against a timeline model derived from the start cycle.
`timescale 1ns/1ps
module tb_ys_poly_small_ctrl3;

  localparam int NA = 509, LA = 1, BA = (NA + 7) / 8;
  localparam int NB = 16,  LB = 2, BB = (NB + 7) / 8;

  logic clk = 1'b0;
  logic rst, startA, startB;

  logic busyA, doneA, r1eaA, r1ebA, fA, w2aA, w2bA;
  logic [6:0] a1aA, a1bA, a2aA, a2bA;
  logic busyB, doneB, r1eaB, r1ebB, fB, w2aB, w2bB;
  logic [6:0] a1aB, a1bB, a2aB, a2bB;
  logic [15:0] cntA, cntB;

  int checks = 0;
  int errors = 0;
  int offA = 0, offB = 0;
  int cntModelA = 0, cntModelB = 0;
  int doneSeenA = 0, writeSeenA = 0;

  always #5 clk = ~clk;

  ys_poly_small_ctrl3 #(.N_COEF(NA), .AW(7), .RD_LAT(LA)) dutA (
    .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA),
    .ram1_ena(r1eaA), .ram1_enb(r1ebA), .ram1_addra(a1aA), .ram1_addrb(a1bA),
    .f_ctr(fA), .ram2_wea(w2aA), .ram2_web(w2bA),
`ifdef YS_POLY_SMALL_CTRL3_CNT_EN
    .cyc_cnt(cntA),
`endif
    .ram2_addra(a2aA), .ram2_addrb(a2bA)
  );

  ys_poly_small_ctrl3 #(.N_COEF(NB), .AW(7), .RD_LAT(LB)) dutB (
    .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB),
    .ram1_ena(r1eaB), .ram1_enb(r1ebB), .ram1_addra(a1aB), .ram1_addrb(a1bB),
    .f_ctr(fB), .ram2_wea(w2aB), .ram2_web(w2bB),
`ifdef YS_POLY_SMALL_CTRL3_CNT_EN
    .cyc_cnt(cntB),
`endif
    .ram2_addra(a2aB), .ram2_addrb(a2bB)
  );

`ifndef YS_POLY_SMALL_CTRL3_CNT_EN
  assign cntA = '0;
  assign cntB = '0;
`endif

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs derived from cycles elapsed since the accepted start (off=0 means idle)
  task automatic checkDut(input string n, input int off, input int beats, input int lat,
                          input logic busy, input logic done, input logic e1a, input logic e1b,
                          input logic [6:0] a1a, input logic [6:0] a1b, input logic fc,
                          input logic w2a, input logic w2b, input logic [6:0] a2a, input logic [6:0] a2b);
    bit rd, wr;
    int k, kw;
    rd = (off >= 1) && (off <= beats);
    wr = (off >= 1 + lat) && (off <= beats + lat);
    k  = off - 1;
    kw = off - 1 - lat;
    checkOutput({n, ".busy"}, 16'(busy), 16'((off >= 1) && (off <= beats + lat)));
    checkOutput({n, ".done"}, 16'(done), 16'(off == beats + lat + 1));
    checkOutput({n, ".ram1_ena"}, 16'(e1a), 16'(rd));
    checkOutput({n, ".ram1_enb"}, 16'(e1b), 16'(rd));
    checkOutput({n, ".ram1_addra"}, 16'(a1a), rd ? 16'(2 * k) : 16'd0);
    checkOutput({n, ".ram1_addrb"}, 16'(a1b), rd ? 16'(2 * k + 1) : 16'd0);
    checkOutput({n, ".ram2_wea"}, 16'(w2a), 16'(wr));
    checkOutput({n, ".ram2_web"}, 16'(w2b), 16'(wr));
    checkOutput({n, ".ram2_addra"}, 16'(a2a), wr ? 16'(2 * kw) : 16'd0);
    checkOutput({n, ".ram2_addrb"}, 16'(a2b), wr ? 16'(2 * kw + 1) : 16'd0);
    checkOutput({n, ".f_ctr"}, 16'(fc), 16'(!(wr && kw == 0)));
  endtask

  function automatic int nextOff(input int off, input logic s, input int last);
    if (off > 0) return (off >= last) ? 0 : off + 1;
    return s ? 1 : 0;
  endfunction

  function automatic int nextCnt(input int cnt, input int off, input logic s, input int beats, input int lat);
    if (off == 0 && s) return 0;
    if (off >= 1 && off <= beats + lat && cnt < 65535) return cnt + 1;
    return cnt;
  endfunction

  // One clock cycle: drive inputs, advance the model across the edge, then check both DUTs
  task automatic applyStimulus(input logic r, input logic sa, input logic sb);
    rst    = r;
    startA = sa;
    startB = sb;
    @(posedge clk);
    if (r) begin
      offA = 0; offB = 0; cntModelA = 0; cntModelB = 0;
    end else begin
      cntModelA = nextCnt(cntModelA, offA, sa, BA, LA);
      cntModelB = nextCnt(cntModelB, offB, sb, BB, LB);
      offA = nextOff(offA, sa, BA + LA + 1);
      offB = nextOff(offB, sb, BB + LB + 1);
    end
    #1;
    checkDut("A", offA, BA, LA, busyA, doneA, r1eaA, r1ebA, a1aA, a1bA, fA, w2aA, w2bA, a2aA, a2bA);
    checkDut("B", offB, BB, LB, busyB, doneB, r1eaB, r1ebB, a1aB, a1bB, fB, w2aB, w2bB, a2aB, a2bB);
`ifdef YS_POLY_SMALL_CTRL3_CNT_EN
    checkOutput("A.cyc_cnt", cntA, 16'(cntModelA));
    checkOutput("B.cyc_cnt", cntB, 16'(cntModelB));
`endif
    if (doneA === 1'b1) doneSeenA++;
    if (w2aA === 1'b1) writeSeenA++;
  endtask

  initial begin
    rst = 1'b1; startA = 1'b0; startB = 1'b0;
    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Full run with ignored re-pulses at t+10 and the DONE cycle, then a fresh run at t+67
    $display("[TB] directed run with re-pulsed start");
    doneSeenA = 0; writeSeenA = 0;
    for (int i = 0; i < 140; i++)
      applyStimulus(1'b0, (i == 0 || i == 10 || i == 66 || i == 67), (i == 0 || i == 3 || i == 5));
    checkOutput("A.doneCount", 16'(doneSeenA), 16'd2);
    checkOutput("A.writeCount", 16'(writeSeenA), 16'd128);

    // Reset during read beat 20, then a complete fresh run
    $display("[TB] mid-run reset");
    doneSeenA = 0; writeSeenA = 0;
    for (int i = 0; i < 21; i++) applyStimulus(1'b0, (i == 0), (i == 0));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("A.doneAfterReset", 16'(doneSeenA), 16'd0);
    for (int i = 0; i < 70; i++) applyStimulus(1'b0, (i == 2), (i == 2));
    checkOutput("A.doneFresh", 16'(doneSeenA), 16'd1);
    checkOutput("A.writeFresh", 16'(writeSeenA), 16'd64 + 16'd20);

    // Random starts and occasional resets
    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
